// File: rtl/seq_divider.sv
// Multi-cycle unsigned radix-2 restoring divider with valid/ready handshakes.
// A zero divisor skips iteration and returns an all-ones quotient with the dividend as remainder.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    // One restoring step: the trial value keeps the shifted-out bit so the compare never loses a carry.
    always_comb begin
        trial_s = {rem_r, quo_r[WIDTH-1]};
        if (trial_s >= {1'b0, divisor_r}) begin
            rem_next_s = trial_s[WIDTH-1:0] - divisor_r;
            quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = trial_s[WIDTH-1:0];
            quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM, working registers and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            divisor_r   <= {WIDTH{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        divisor_r  <= divisor;
                        cnt_r      <= {CW{1'b0}};
                        rem_r      <= {WIDTH{1'b0}};
                        quo_r      <= dividend;
                        in_ready_r <= 1'b0;
                        if (divisor == {WIDTH{1'b0}}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            quotient_r  <= {WIDTH{1'b1}};
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == LAST_ITER) begin
                        state_r     <= DONE;
                        cnt_r       <= {CW{1'b0}};
                        out_valid_r <= 1'b1;
                        quotient_r  <= quo_next_s;
                        remainder_r <= rem_next_s;
                        dbz_r       <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, handshake/reset corner cases,
// exhaustive WIDTH=4 sweep and a random WIDTH=8 sample against a plain-arithmetic model.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv4, ir4, ov4, or4, dz4;
    logic [3:0] a4, b4, q4, r4;
    logic       iv8, ir8, ov8, or8, dz8;
    logic [7:0] a8, b8, q8, r8;

    seq_divider #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .dividend(a4), .divisor(b4), .out_valid(ov4), .out_ready(or4),
        .quotient(q4), .remainder(r4), .div_by_zero(dz4)
    );

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .dividend(a8), .divisor(b8), .out_valid(ov8), .out_ready(or8),
        .quotient(q8), .remainder(r8), .div_by_zero(dz8)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] get_q(input int w);
        return (w == 4) ? 32'(q4) : 32'(q8);
    endfunction
    function automatic logic [31:0] get_r(input int w);
        return (w == 4) ? 32'(r4) : 32'(r8);
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 4) ? dz4 : dz8;
    endfunction
    function automatic logic get_ov(input int w);
        return (w == 4) ? ov4 : ov8;
    endfunction
    function automatic logic get_ir(input int w);
        return (w == 4) ? ir4 : ir8;
    endfunction

    task automatic drive_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (w == 4) begin
            iv4 = v; a4 = a[3:0]; b4 = b[3:0];
        end else begin
            iv8 = v; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic set_ordy(input int w, input logic v);
        if (w == 4) or4 = v;
        else or8 = v;
    endtask

    // Reference: plain division; latency counted in clock edges after the accepting edge.
    // A zero divisor is resolved on the accepting edge itself, so it is visible the next cycle.
    task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz, output int lat);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        if (b == 32'd0) begin
            q = mask; r = a; dz = 1'b1; lat = 0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = w;
        end
    endtask

    // Called at a negedge: issue one operation, measure latency, optionally stall, then handshake.
    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int elat, input int stall, input bit toggle, input string tag);
        int lat;
        int guard;
        guard = 0;
        while (!get_ir(w) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_in_ready_before"}, 32'(get_ir(w)), 32'd1);
        set_ordy(w, (stall == 0) ? 1'b1 : 1'b0);
        drive_in(w, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive_in(w, 1'b0, $urandom, $urandom);
        lat = 0;
        while (!get_ov(w) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        for (int i = 0; i < stall; i++) begin
            check({tag, "_hold_q"}, get_q(w), eq);
            check({tag, "_hold_r"}, get_r(w), er);
            check({tag, "_hold_ov"}, 32'(get_ov(w)), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(get_ir(w)), 32'd0);
            if (toggle) drive_in(w, 1'($urandom_range(0, 1)), $urandom, $urandom);
            @(negedge clk);
        end
        drive_in(w, 1'b0, 32'd0, 32'd0);
        set_ordy(w, 1'b1);
        check({tag, "_q"}, get_q(w), eq);
        check({tag, "_r"}, get_r(w), er);
        check({tag, "_dz"}, 32'(get_dz(w)), 32'(edz));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_in_ready_after"}, 32'(get_ir(w)), 32'd1);
        check({tag, "_ov_after"}, 32'(get_ov(w)), 32'd0);
    endtask

    task automatic check_reset_state(input int w, input string tag);
        check({tag, "_q"}, get_q(w), 32'd0);
        check({tag, "_r"}, get_r(w), 32'd0);
        check({tag, "_dz"}, 32'(get_dz(w)), 32'd0);
        check({tag, "_ov"}, 32'(get_ov(w)), 32'd0);
        check({tag, "_in_ready"}, 32'(get_ir(w)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] mq, mr;
        logic        mdz;
        int          mlat;
        logic [31:0] ra, rb;

        vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, dz: 1'b0, lat: 4};
        vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 4};
        vecs[2] = '{a: 4'd3,  b: 4'd9,  q: 4'd0,  r: 4'd3, dz: 1'b0, lat: 4};
        vecs[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 4};
        vecs[4] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 4};
        vecs[5] = '{a: 4'd7,  b: 4'd0,  q: 4'd15, r: 4'd7, dz: 1'b1, lat: 0};

        drive_in(4, 1'b0, 32'd0, 32'd0);
        drive_in(8, 1'b0, 32'd0, 32'd0);
        set_ordy(4, 1'b0);
        set_ordy(8, 1'b0);
        repeat (3) @(negedge clk);
        check_reset_state(4, "reset4");
        check_reset_state(8, "reset8");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(4, 32'(vecs[i].a), 32'(vecs[i].b), 32'(vecs[i].q), 32'(vecs[i].r),
                   vecs[i].dz, vecs[i].lat, 0, 1'b0, $sformatf("vec%0d", i));

        // Consumer stalls six cycles while upstream keeps offering new operands.
        run_op(4, 32'd14, 32'd3, 32'd4, 32'd2, 1'b0, 4, 6, 1'b1, "stall_14_3");

        // Asynchronous reset between edges, two iterations into 11/2.
        drive_in(4, 1'b1, 32'd11, 32'd2);
        @(posedge clk);
        @(negedge clk);
        drive_in(4, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state(4, "midcalc_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4, 32'd9, 32'd4, 32'd2, 32'd1, 1'b0, 4, 0, 1'b0, "after_reset_9_4");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                model(4, 32'(a), 32'(b), mq, mr, mdz, mlat);
                run_op(4, 32'(a), 32'(b), mq, mr, mdz, mlat, $urandom_range(0, 3), 1'b0,
                       $sformatf("sweep4_%0d_%0d", a, b));
            end
        end

        for (int n = 0; n < 300; n++) begin
            ra = 32'($urandom_range(0, 255));
            rb = (n % 20 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            model(8, ra, rb, mq, mr, mdz, mlat);
            run_op(8, ra, rb, mq, mr, mdz, mlat, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   $sformatf("rand8_%0d_%0d", ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
